// File: rtl/column_pkg.sv
// Shared types and constants for the animated VGA level column.
// Latency: n/a (types only).
// Backpressure: n/a.
package column_pkg;

  // Width of the VGA pixel coordinates (Q_X/Q_Y) and of every pixel-space quantity.
  localparam int COORD_W = 10;

  // Animation FSM states.
  typedef enum logic [1:0] {
    IDLE,
    RISE,
    FALL,
    DONE
  } col_state_t;

endpackage

// File: rtl/column_rect_hit.sv
// Half-open box test: hit = X0 <= q_x < X1 and Y0 <= q_y < Y1 (unsigned).
// Latency: combinational, 0 cycles.
// Backpressure: none.
// Ports: q_x, q_y (pixel coordinates) in; hit out.
module column_rect_hit
  import column_pkg::*;
#(
  parameter int X0 = 0,
  parameter int X1 = 1,
  parameter int Y0 = 0,
  parameter int Y1 = 1
) (
  input  logic [COORD_W-1:0] q_x,
  input  logic [COORD_W-1:0] q_y,
  output logic               hit
);

  localparam logic [COORD_W-1:0] X0_C = COORD_W'(X0);
  localparam logic [COORD_W-1:0] X1_C = COORD_W'(X1);
  localparam logic [COORD_W-1:0] Y0_C = COORD_W'(Y0);
  localparam logic [COORD_W-1:0] Y1_C = COORD_W'(Y1);

  assign hit = (q_x >= X0_C) && (q_x < X1_C) && (q_y >= Y0_C) && (q_y < Y1_C);

endmodule

// File: rtl/column_level_anim.sv
// Animated VGA column: outer frame plus interior fill bar gliding STEP_PX per frame toward a requested level.
// Latency: pixel flags 1 clk after Q_X/Q_Y; fill moves only on frame_tick; done pulses 1 cycle on arrival.
// Backpressure: level_ready=1 only in IDLE; requests while busy are not accepted and not queued.
// Ports: clk, rst_n; frame_tick; Q_X/Q_Y pixel coords; level_valid/level/level_ready request handshake;
//        highlight (blink frame); busy, done status; Area_front, fill registered pixel flags.
module column_level_anim
  import column_pkg::*;
#(
  parameter int  X_START      = 10,
  parameter int  Y_START      = 240,
  parameter int  WIDTH        = 300,
  parameter int  HEIGHT       = 110,
  parameter int  BORDER       = 10,
  parameter int  N_SLOTS      = 6,
  parameter int  STEP_PX      = 3,
  parameter int  BLINK_FRAMES = 16,
  localparam int LW           = $clog2(N_SLOTS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic [COORD_W-1:0] Q_X,
  input  logic [COORD_W-1:0] Q_Y,
  input  logic               level_valid,
  input  logic [LW-1:0]      level,
  output logic               level_ready,
  input  logic               highlight,
  output logic               busy,
  output logic               done,
  output logic               Area_front,
  output logic               fill
);

  localparam int SLOT_H = (HEIGHT - 2 * BORDER) / N_SLOTS;
  localparam int BW     = $clog2(BLINK_FRAMES) + 1;

  localparam logic [COORD_W-1:0] SLOT_C  = COORD_W'(SLOT_H);
  localparam logic [COORD_W-1:0] NSLOT_C = COORD_W'(N_SLOTS);
  localparam logic [COORD_W-1:0] STEP_C  = COORD_W'(STEP_PX);
  localparam logic [COORD_W-1:0] YB_C    = COORD_W'(Y_START + HEIGHT - BORDER);
  localparam logic [BW-1:0]      BLINK_LAST = BW'(BLINK_FRAMES - 1);

  col_state_t         state, state_nxt;
  logic [COORD_W-1:0] fill_px, fill_nxt;
  logic [COORD_W-1:0] target_px, target_nxt;
  logic [COORD_W-1:0] lvl_ext, lvl_clamp, req_px;
  logic [COORD_W:0]   rise_sum;
  logic               ready_en;
  logic               accept;
  logic [BW-1:0]      blink_cnt;
  logic               vis;
  logic               outer_hit, inner_hit, bar_hit;

  // Request decode: clamp to the top slot, convert to a pixel height.
  assign lvl_ext   = COORD_W'(level);
  assign lvl_clamp = (lvl_ext > NSLOT_C) ? NSLOT_C : lvl_ext;
  assign req_px    = lvl_clamp * SLOT_C;

  // ready_en keeps level_ready low while in reset and for the first edge after release.
  assign level_ready = ready_en && (state == IDLE);
  assign accept      = level_valid && level_ready;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

  // One extra bit so fill+STEP never wraps before comparing against the target.
  assign rise_sum = {1'b0, fill_px} + {1'b0, STEP_C};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fill_px   <= '0;
      target_px <= '0;
      ready_en  <= 1'b0;
    end else begin
      state     <= state_nxt;
      fill_px   <= fill_nxt;
      target_px <= target_nxt;
      ready_en  <= 1'b1;
    end
  end

  // IDLE ignores frame_tick, so an accept coincident with a tick steps on the next tick.
  always_comb begin
    state_nxt  = state;
    fill_nxt   = fill_px;
    target_nxt = target_px;
    case (state)
      IDLE: begin
        if (accept) begin
          target_nxt = req_px;
          if (req_px > fill_px)      state_nxt = RISE;
          else if (req_px < fill_px) state_nxt = FALL;
          else                       state_nxt = DONE;
        end
      end
      RISE: begin
        if (frame_tick) begin
          if (rise_sum >= {1'b0, target_px}) begin
            fill_nxt  = target_px;
            state_nxt = DONE;
          end else begin
            fill_nxt = rise_sum[COORD_W-1:0];
          end
        end
      end
      FALL: begin
        // fill_px > target_px here, so the difference cannot underflow.
        if (frame_tick) begin
          if ((fill_px - target_px) <= STEP_C) begin
            fill_nxt  = target_px;
            state_nxt = DONE;
          end else begin
            fill_nxt = fill_px - STEP_C;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Blink: vis flips every BLINK_FRAMES ticks while highlighted, forced visible otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      vis       <= 1'b1;
    end else if (!highlight) begin
      blink_cnt <= '0;
      vis       <= 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        vis       <= ~vis;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  column_rect_hit #(
    .X0(X_START),
    .X1(X_START + WIDTH),
    .Y0(Y_START),
    .Y1(Y_START + HEIGHT)
  ) u_outer (
    .q_x(Q_X),
    .q_y(Q_Y),
    .hit(outer_hit)
  );

  column_rect_hit #(
    .X0(X_START + BORDER),
    .X1(X_START + WIDTH - BORDER),
    .Y0(Y_START + BORDER),
    .Y1(Y_START + HEIGHT - BORDER)
  ) u_inner (
    .q_x(Q_X),
    .q_y(Q_Y),
    .hit(inner_hit)
  );

  // Bar grows upward from the exclusive bottom YB; fill_px=0 gives Q_Y>=YB, which inner excludes.
  assign bar_hit = inner_hit && (Q_Y >= (YB_C - fill_px));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Area_front <= 1'b0;
      fill       <= 1'b0;
    end else begin
      Area_front <= outer_hit && !inner_hit && vis;
      fill       <= bar_hit;
    end
  end

endmodule

// File: tb/tb_column_level_anim.sv
// Self-checking bench for column_level_anim with default geometry (SLOT_H=15, YB=340, interior x 20..299).
// Latency: n/a (bench).
// Backpressure: n/a.
module tb_column_level_anim;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic [9:0] Q_X = '0;
  logic [9:0] Q_Y = '0;
  logic       level_valid = 1'b0;
  logic [2:0] level = '0;
  logic       highlight = 1'b0;
  logic       level_ready, busy, done, Area_front, fill;

  int errors = 0;
  int checks = 0;

  // Reference model: bar height and goal in pixels.
  int m_fill   = 0;
  int m_target = 0;

  always #5 clk = ~clk;

  column_level_anim dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .Q_X        (Q_X),
    .Q_Y        (Q_Y),
    .level_valid(level_valid),
    .level      (level),
    .level_ready(level_ready),
    .highlight  (highlight),
    .busy       (busy),
    .done       (done),
    .Area_front (Area_front),
    .fill       (fill)
  );

  // Slot level -> pixel height, with clamping to six slots of 15 px.
  function automatic int level_to_px(input int l);
    return ((l > 6) ? 6 : l) * 15;
  endfunction

  // One 3 px move toward the goal, never passing it.
  function automatic int step_toward(input int f, input int t);
    if (t > f) return (f + 3 > t) ? t : f + 3;
    return (f - 3 < t) ? t : f - 3;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input int x, input int y, output logic af, output logic fl);
    Q_X = 10'(x);
    Q_Y = 10'(y);
    cyc();
    af = Area_front;
    fl = fill;
  endtask

  // Bar top row must be lit (if any fill), row just above must be dark.
  task automatic check_bar(input string tag);
    int   x = $urandom_range(20, 299);
    logic af, fl;
    probe(x, 340 - m_fill, af, fl);
    checks++;
    if (fl !== (m_fill > 0)) begin
      errors++;
      $display("FAIL bar_top %s fill_px=%0d x=%0d: got %b want %b", tag, m_fill, x, fl, m_fill > 0);
    end
    checks++;
    if (af !== (m_fill == 0)) begin
      errors++;
      $display("FAIL bar_top_af %s fill_px=%0d: got %b want %b", tag, m_fill, af, m_fill == 0);
    end
    probe(x, 339 - m_fill, af, fl);
    checks++;
    if (fl !== 1'b0) begin
      errors++;
      $display("FAIL bar_above %s fill_px=%0d x=%0d: got %b want 0", tag, m_fill, x, fl);
    end
  endtask

  task automatic request(input int l);
    int n = 0;
    level       = 3'(l);
    level_valid = 1'b1;
    while (level_ready !== 1'b1 && n < 200) begin
      cyc();
      n++;
    end
    checks++;
    if (level_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_timeout level=%0d: got %b want 1", l, level_ready);
    end
    cyc();
    level_valid = 1'b0;
    m_target    = level_to_px(l);
    if (m_target == m_fill) begin
      checks++;
      if (done !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL req_equal_done level=%0d: got done=%b busy=%b want 1 1", l, done, busy);
      end
      cyc();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || level_ready !== 1'b1) begin
        errors++;
        $display("FAIL req_equal_idle: got done=%b busy=%b ready=%b want 0 0 1", done, busy, level_ready);
      end
    end else begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || level_ready !== 1'b0) begin
        errors++;
        $display("FAIL req_start level=%0d: got busy=%b done=%b ready=%b want 1 0 0", l, busy, done, level_ready);
      end
    end
  endtask

  // Ticks until the model arrives; random idle gaps between ticks.
  task automatic run_anim(input int gap_max);
    int guard = 0;
    while (m_fill != m_target && guard < 100) begin
      guard++;
      repeat ($urandom_range(0, gap_max)) cyc();
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      m_fill = step_toward(m_fill, m_target);
      if (m_fill == m_target) begin
        checks++;
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL anim_done fill_px=%0d: got %b want 1", m_fill, done);
        end
        cyc();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || level_ready !== 1'b1) begin
          errors++;
          $display("FAIL anim_idle: got done=%b busy=%b ready=%b want 0 0 1", done, busy, level_ready);
        end
      end else begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || level_ready !== 1'b0) begin
          errors++;
          $display("FAIL anim_step fill_px=%0d: got done=%b busy=%b ready=%b want 0 1 0",
                   m_fill, done, busy, level_ready);
        end
        check_bar("step");
      end
    end
  endtask

  task automatic test_reset();
    Q_X = 10'd15;
    Q_Y = 10'd300;
    repeat (3) cyc();
    checks++;
    if ({level_ready, busy, done, Area_front, fill} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000", {level_ready, busy, done, Area_front, fill});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (level_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_ready_early: got %b want 0", level_ready);
    end
    cyc();
    checks++;
    if (level_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", level_ready);
    end
  endtask

  task automatic test_levels();
    logic af, fl;
    request(2);
    run_anim(2);
    probe(100, 310, af, fl);
    checks++;
    if (fl !== 1'b1) begin errors++; $display("FAIL lvl2_px_100_310: got %b want 1", fl); end
    probe(100, 309, af, fl);
    checks++;
    if (fl !== 1'b0) begin errors++; $display("FAIL lvl2_px_100_309: got %b want 0", fl); end
    probe(19, 320, af, fl);
    checks++;
    if (fl !== 1'b0 || af !== 1'b1) begin
      errors++;
      $display("FAIL lvl2_px_19_320: got fill=%b af=%b want 0 1", fl, af);
    end
    request(1);
    run_anim(1);
    check_bar("lvl1");
    request(7);
    run_anim(0);
    check_bar("lvl7");
  endtask

  task automatic test_busy();
    request(4);
    level_valid = 1'b1;  // held through the whole animation; must not be taken early
    level       = 3'd0;
    run_anim(1);
    request(0);
    run_anim(0);
    check_bar("busy");
  endtask

  task automatic test_equal();
    request(0);
    check_bar("equal");
  endtask

  task automatic test_accept_tick();
    request(2);
    run_anim(0);
    level       = 3'd4;
    level_valid = 1'b1;
    frame_tick  = 1'b1;
    cyc();
    level_valid = 1'b0;
    frame_tick  = 1'b0;
    m_target    = level_to_px(4);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL acc_tick_busy: got %b want 1", busy); end
    check_bar("acc_tick");
    run_anim(1);
    check_bar("acc_tick_end");
  endtask

  task automatic test_blink();
    logic af, fl;
    highlight = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      probe(15, 300, af, fl);
      checks++;
      if (af !== (((k / 16) % 2) == 0)) begin
        errors++;
        $display("FAIL blink ticks=%0d: got %b want %b", k, af, ((k / 16) % 2) == 0);
      end
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
    end
    repeat (7) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
    end
    probe(15, 300, af, fl);
    checks++;
    if (af !== 1'b0) begin errors++; $display("FAIL blink_48_off: got %b want 0", af); end
    highlight = 1'b0;
    cyc();
    probe(15, 300, af, fl);
    checks++;
    if (af !== 1'b1) begin errors++; $display("FAIL blink_release: got %b want 1", af); end
  endtask

  task automatic test_pixel_lag();
    int   xs[6] = '{309, 310, 100, 10, 9, 10};
    int   ys[6] = '{349, 300, 300, 240, 240, 239};
    logic exp[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic af, fl;
    Q_X = 10'd15;
    Q_Y = 10'd300;
    cyc();
    Q_X = 10'd100;
    Q_Y = 10'd100;
    #1;
    checks++;
    if (Area_front !== 1'b1) begin errors++; $display("FAIL lag_hold: got %b want 1", Area_front); end
    cyc();
    checks++;
    if (Area_front !== 1'b0) begin errors++; $display("FAIL lag_update: got %b want 0", Area_front); end
    for (int i = 0; i < 6; i++) begin
      probe(xs[i], ys[i], af, fl);
      checks++;
      if (af !== exp[i]) begin
        errors++;
        $display("FAIL edge_px (%0d,%0d): got %b want %b", xs[i], ys[i], af, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    request(6);
    repeat (2) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      m_fill = step_toward(m_fill, m_target);
    end
    Q_X   = 10'd100;
    Q_Y   = 10'd339;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({level_ready, busy, done, Area_front, fill} !== 5'b0) begin
      errors++;
      $display("FAIL rst_mid_now: got %b want 00000", {level_ready, busy, done, Area_front, fill});
    end
    repeat (4) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      Q_X = 10'd15;
      Q_Y = 10'd300;
      checks++;
      if ({level_ready, busy, done, Area_front, fill} !== 5'b0) begin
        errors++;
        $display("FAIL rst_mid_hold: got %b want 00000", {level_ready, busy, done, Area_front, fill});
      end
    end
    rst_n = 1'b1;
    cyc();
    m_fill   = 0;
    m_target = 0;
    checks++;
    if (level_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_release: got ready=%b busy=%b done=%b want 1 0 0", level_ready, busy, done);
    end
    check_bar("rst_mid");
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      int l = $urandom_range(0, 7);
      request(l);
      if (m_target != m_fill) run_anim(3);
      check_bar("rand");
    end
  endtask

  initial begin
    test_reset();
    test_levels();
    test_busy();
    test_equal();
    test_accept_tick();
    test_blink();
    test_pixel_lag();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
